// File: rtl/motion_segment_executor_pkg.sv
// Shared types for the motion-segment executor: the fifo record layout and FSM states.
package beagleg;
  localparam int FractionBits = 32;
  localparam int MaxAxes = 8;

  // Executors built with fewer than MaxAxes channels use the low-order entries.
  typedef struct packed {
    logic [MaxAxes-1:0]                   dir;
    logic [MaxAxes-1:0][FractionBits-1:0] fraction;
    logic [31:0]                          loops;
    logic [31:0]                          loop_cycles;
  } MotionSegment;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    DIR_WAIT = 3'd3,
    RUN      = 3'd4
  } state_e;
endpackage

// File: rtl/motion_segment_executor_dda_axis.sv
// One step channel: 32-bit DDA accumulator whose carry-out launches a fixed-width step pulse.
module dda_axis
  import beagleg::*;
#(
  parameter int StepPulseCycles = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tick,
  input  logic [FractionBits-1:0] fraction,
  output logic                    step
);
  localparam int CntW = $clog2(StepPulseCycles + 1);

  logic [FractionBits-1:0] acc;
  logic [FractionBits:0]   sum;
  logic [CntW-1:0]         pulse_cnt;

  assign sum = {1'b0, acc} + {1'b0, fraction};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      pulse_cnt <= '0;
      step      <= 1'b0;
    end else begin
      if (clear) acc <= '0;
      else if (tick) acc <= sum[FractionBits-1:0];
      // pulse_cnt holds the remaining high cycles after the current one
      if (tick && sum[FractionBits]) begin
        step      <= 1'b1;
        pulse_cnt <= CntW'(StepPulseCycles - 1);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end else begin
        step <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/motion_segment_executor.sv
// Constant-velocity multi-axis step generator fed by the motion-segment fifo.
// Fifo handshake: data_request is a one-cycle strobe issued only while data_available is high; the record on data is valid the following cycle (LOAD).
module motion_segment_executor
  import beagleg::*;
#(
  parameter int Axes            = 8,
  parameter int StepPulseCycles = 4,
  parameter int DirSetupCycles  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           data_available,
  output logic                           data_request,
  input  logic [$bits(MotionSegment)-1:0] data,
  output logic [Axes-1:0]                step,
  output logic [Axes-1:0]                dir,
  output logic                           busy,
  output logic [2:0]                     state
);
  localparam logic [31:0] MinLoop   = 32'(2 * StepPulseCycles);
  localparam logic [31:0] SetupLast = 32'(DirSetupCycles - 1);

  state_e       state_q, state_d;
  MotionSegment seg;
  logic [31:0]  eff_len;
  logic [Axes-1:0][FractionBits-1:0] fraction_q;
  logic [31:0]  loops_q, loop_len_q, loop_cnt, timer, setup_cnt;
  logic         loop_end, last_loop, tick, load;

  assign seg       = MotionSegment'(data);
  assign eff_len   = (seg.loop_cycles < MinLoop) ? MinLoop : seg.loop_cycles;
  assign loop_end  = (timer == loop_len_q - 32'd1);
  assign last_loop = (loop_cnt == loops_q - 32'd1);
  assign tick      = (state_q == RUN) && (timer == 32'd0);
  assign load      = (state_q == LOAD);
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (data_available) state_d = FETCH;
      FETCH:    state_d = LOAD;
      LOAD: begin
        if (seg.loops == 32'd0)                 state_d = data_available ? FETCH : IDLE;
        else if (seg.dir[Axes-1:0] != dir)      state_d = DIR_WAIT;
        else                                    state_d = RUN;
      end
      DIR_WAIT: if (setup_cnt == SetupLast) state_d = RUN;
      RUN:      if (loop_end && last_loop) state_d = data_available ? FETCH : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_request <= 1'b0;
      busy         <= 1'b0;
      dir          <= '0;
      fraction_q   <= '0;
      loops_q      <= '0;
      loop_len_q   <= '0;
      loop_cnt     <= '0;
      timer        <= '0;
      setup_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      data_request <= (state_d == FETCH);
      busy         <= (state_d != IDLE);
      case (state_q)
        LOAD: begin
          fraction_q <= seg.fraction[Axes-1:0];
          loops_q    <= seg.loops;
          loop_len_q <= eff_len;
          loop_cnt   <= '0;
          timer      <= '0;
          setup_cnt  <= '0;
          // an empty segment is dropped without touching dir
          if (seg.loops != 32'd0) dir <= seg.dir[Axes-1:0];
        end
        DIR_WAIT: setup_cnt <= setup_cnt + 32'd1;
        RUN: begin
          if (loop_end) begin
            timer    <= '0;
            loop_cnt <= loop_cnt + 32'd1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < Axes; i++) begin : g_axis
    dda_axis #(.StepPulseCycles(StepPulseCycles)) u_dda (
      .clk      (clk),
      .reset    (reset),
      .clear    (load),
      .tick     (tick),
      .fraction (fraction_q[i]),
      .step     (step[i])
    );
  end
endmodule

// File: tb/tb_motion_segment_executor.sv
// Directed bench for motion_segment_executor: fifo model, event scoreboard and direct level checks.
module tb_motion_segment_executor;
  import beagleg::*;

  localparam int W = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                            data_available;
  logic                            data_request;
  logic [$bits(MotionSegment)-1:0] data;
  logic [1:0]                      step;
  logic [1:0]                      dir;
  logic                            busy;
  logic [2:0]                      state;

  motion_segment_executor #(
    .Axes(2), .StepPulseCycles(4), .DirSetupCycles(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_available (data_available),
    .data_request   (data_request),
    .data           (data),
    .step           (step),
    .dir            (dir),
    .busy           (busy),
    .state          (state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- fifo model ----------------
  MotionSegment fifo_mem[16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign data_available = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (data_request && (rd_ptr != wr_ptr)) begin
      data   <= fifo_mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // event codes: 1 = data_request, 2 = step0 rise, 3 = step1 rise
  task automatic exp_ev(int code, int t);
    exp_q.push_back({8'(code), 32'(t)});
  endtask

  task automatic observe(int code);
    logic [W-1:0] e;
    logic [W-1:0] a;
    a = {8'(code), 32'(cyc)};
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", code, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e == a) passes++;
      else $display("FAIL event: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                    code, cyc, int'(e[39:32]), int'(e[31:0]));
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0] prev_step = 2'b00;
  logic [1:0] prev_dir  = 2'b00;
  int hi_len[2] = '{0, 0};

  always @(negedge clk) begin
    if (data_request) observe(1);
    for (int i = 0; i < 2; i++)
      if (step[i] && !prev_step[i]) observe(2 + i);
    if (dir != prev_dir) check("step_low_on_dir_change", int'(step), 0);
    for (int i = 0; i < 2; i++) begin
      if (step[i]) hi_len[i]++;
      else begin
        if (prev_step[i] && !reset) check("pulse_width", hi_len[i], 4);
        hi_len[i] = 0;
      end
    end
    prev_step = step;
    prev_dir  = dir;
  end

  // ---------------- driver helpers ----------------
  function automatic MotionSegment make_seg(logic [1:0] d, logic [31:0] f0, logic [31:0] f1,
                                            logic [31:0] loops, logic [31:0] lc);
    MotionSegment s;
    s = '0;
    s.dir[1:0]    = d;
    s.fraction[0] = f0;
    s.fraction[1] = f1;
    s.loops       = loops;
    s.loop_cycles = lc;
    return s;
  endfunction

  task automatic push_seg(MotionSegment s);
    fifo_mem[wr_ptr % 16] = s;
    wr_ptr++;
  endtask

  task automatic at_cycle(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int bad;

    repeat (3) @(negedge clk);
    check("reset_step", int'(step), 0);
    check("reset_dir", int'(dir), 0);
    check("reset_data_request", int'(data_request), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(state), int'(IDLE));
    reset = 1'b0;

    // empty fifo: nothing moves
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (data_request || busy || (step != 2'b00)) bad++;
    end
    check("empty_fifo_quiet", bad, 0);

    // basic rate test
    @(negedge clk); t0 = cyc;
    push_seg(make_seg(2'b00, 32'h8000_0000, 32'h4000_0000, 8, 10));
    exp_ev(1, t0 + 1);
    exp_ev(2, t0 + 14); exp_ev(2, t0 + 34); exp_ev(3, t0 + 34);
    exp_ev(2, t0 + 54); exp_ev(2, t0 + 74); exp_ev(3, t0 + 74);
    at_cycle(t0 + 1);  check("t1_busy_fetch", int'(busy), 1);
    at_cycle(t0 + 3);  check("t1_state_run_start", int'(state), int'(RUN));
    at_cycle(t0 + 82); check("t1_state_run_last", int'(state), int'(RUN));
    at_cycle(t0 + 83); check("t1_busy_done", int'(busy), 0);
    repeat (3) @(negedge clk);

    // back-to-back with dir[0] flip
    @(negedge clk); t0 = cyc;
    push_seg(make_seg(2'b00, 32'h8000_0000, 32'h0, 2, 10));
    push_seg(make_seg(2'b01, 32'h8000_0000, 32'h0, 2, 10));
    exp_ev(1, t0 + 1); exp_ev(2, t0 + 14); exp_ev(1, t0 + 23); exp_ev(2, t0 + 44);
    at_cycle(t0 + 1);
    bad = 0;
    while (cyc <= t0 + 52) begin
      if (!busy) bad++;
      if (cyc == t0 + 24) check("t2_dir_before", int'(dir), 0);
      if (cyc == t0 + 25) begin
        check("t2_dir_after", int'(dir), 1);
        check("t2_state_dir_wait", int'(state), int'(DIR_WAIT));
      end
      @(negedge clk);
    end
    check("t2_busy_held", bad, 0);
    at_cycle(t0 + 53); check("t2_busy_done", int'(busy), 0);
    repeat (3) @(negedge clk);

    // clamp of a 1-cycle loop
    @(negedge clk); t0 = cyc;
    push_seg(make_seg(2'b01, 32'hFFFF_FFFF, 32'h0, 4, 1));
    exp_ev(1, t0 + 1); exp_ev(2, t0 + 12); exp_ev(2, t0 + 20); exp_ev(2, t0 + 28);
    at_cycle(t0 + 34); check("t3_busy_last_run", int'(busy), 1);
    at_cycle(t0 + 35); check("t3_busy_done", int'(busy), 0);
    repeat (3) @(negedge clk);

    // zero-loop segment then normal segment
    @(negedge clk); t0 = cyc;
    push_seg(make_seg(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10));
    push_seg(make_seg(2'b01, 32'h0, 32'h8000_0000, 2, 10));
    exp_ev(1, t0 + 1); exp_ev(1, t0 + 3); exp_ev(3, t0 + 16);
    at_cycle(t0 + 3);  check("t4_dir_kept", int'(dir), 1);
    at_cycle(t0 + 5);  check("t4_state_run", int'(state), int'(RUN));
    at_cycle(t0 + 24); check("t4_busy_last_run", int'(busy), 1);
    at_cycle(t0 + 25); check("t4_busy_done", int'(busy), 0);
    repeat (3) @(negedge clk);

    // reset during a step pulse
    @(negedge clk); t0 = cyc;
    push_seg(make_seg(2'b11, 32'h8000_0000, 32'h8000_0000, 4, 10));
    exp_ev(1, t0 + 1); exp_ev(2, t0 + 22); exp_ev(3, t0 + 22);
    at_cycle(t0 + 3);  check("t5_dir_set", int'(dir), 3);
    at_cycle(t0 + 23); check("t5_step_high", int'(step), 3);
    reset = 1'b1;
    at_cycle(t0 + 24);
    check("t5_rst_step", int'(step), 0);
    check("t5_rst_dir", int'(dir), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_state", int'(state), int'(IDLE));
    push_seg(make_seg(2'b00, 32'h8000_0000, 32'h0, 2, 10));
    exp_ev(1, t0 + 26); exp_ev(2, t0 + 39);
    at_cycle(t0 + 25); check("t5_no_req_in_reset", int'(data_request), 0);
    reset = 1'b0;
    at_cycle(t0 + 26); check("t5_req_after_reset", int'(data_request), 1);
    at_cycle(t0 + 48); check("t5_busy_done", int'(busy), 0);
    repeat (5) @(negedge clk);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/motion_segment_executor.md
# motion_segment_executor

Multi-axis constant-velocity step generator that consumes `beagleg::MotionSegment` records from the motion-segment fifo and produces step/direction pulses for the stepper drivers. Per axis, a 32-bit DDA accumulator adds that axis's `fraction` once per loop; each carry-out emits one step pulse. It sits directly downstream of the motion-segment fifo, on the fifo's `read_en` / `data_out` / `empty` handshake.

## Interface
- `Axes`, default 8: number of step/dir channels.
- `StepPulseCycles`, default 4: step pulse high width, in clocks.
- `DirSetupCycles`, default 8: minimum number of clocks between a dir change and the next step rising edge.
- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `data_available`  in  1  fifo not empty.
- `data_request`  out  1  one-cycle read strobe to the fifo.
- `data`  in  `$bits(beagleg::MotionSegment)`  segment record. Valid the cycle after `data_request`.
- `step`  out  Axes  step pulses, active high.
- `dir`  out  Axes  direction levels. 1 = positive.
- `busy`  out  1  high while a segment is loaded or executing.

## Operation
- Segment fields:
  - `dir[Axes]`
  - `fraction[Axes]` (32-bit)
  - `loops` (32-bit)
  - `loop_cycles` (32-bit)
- States: IDLE, FETCH, LOAD, DIR_WAIT, RUN.
- IDLE:
  - If `data_available` = 1, go to FETCH.
  - Otherwise stay in IDLE; `busy` = 0.
- FETCH:
  - Assert `data_request` for exactly one cycle, then go to LOAD.
- LOAD:
  - Latch `data`.
  - Clear all accumulators to 0.
  - Set effective loop length = max(`loop_cycles`, 2*StepPulseCycles).
  - If `loops` = 0: discard the segment with no steps and no dir change, then go to FETCH if `data_available` = 1, else IDLE.
  - Else, if the new `dir` differs from the current `dir`: update `dir` and go to DIR_WAIT.
  - Else go to RUN.
- DIR_WAIT:
  - Count DirSetupCycles clocks, then go to RUN.
- RUN, per loop:
  - On the first cycle of the loop, every accumulator adds its `fraction`, keeping the low 32 bits.
  - A carry-out on an axis raises `step[i]` on the next cycle, for StepPulseCycles cycles.
  - The loop lasts exactly the effective loop length.
  - After `loops` loops: go to FETCH if `data_available` = 1, else IDLE.
- `dir` never changes while any `step` bit is high. The 2*StepPulseCycles clamp on loop length guarantees this.
- `data_request` is never asserted when `data_available` = 0.
- `reset` mid-operation:
  - Clears the state to IDLE, and clears all accumulators and counters.
  - Forces `step` to 0 immediately (next edge), truncating any pulse in progress.
  - Forces `dir` to 0.
  - The partially executed segment is lost.

## Timing
- Reset values: `step` = 0, `dir` = 0, `data_request` = 0, `busy` = 0, state = IDLE.
- All outputs are registered.
- Latency from `data_available` rising in IDLE:
  - `data_request` at +1 cycle.
  - LOAD at +2.
  - First RUN cycle at +3 (no dir change) or +3+DirSetupCycles (dir change).
- A step rises 1 cycle after the accumulate cycle.
- Segment duration in RUN = `loops` × effective loop length, exactly.
- Back-to-back segments: 2 cycles (FETCH, LOAD) between the last RUN cycle and the next accumulate, plus DIR_WAIT if `dir` changes. `busy` stays high throughout.
- `busy` = 1 from FETCH through the end of RUN.

## Structure
- Package `beagleg`:
  - `MotionSegment` packed struct holding the fields listed under Operation.
  - Typedef `state_e` for this block's states.
  - Constant `FractionBits` = 32.
- Sub-module `dda_axis`, one instance per axis:
  - Accumulator, carry detect, and pulse-width counter.
  - Inputs: `clk`, `reset`, `clear`, `tick`, `fraction`.
  - Output: `step`.
- The top module holds the FSM, loop counter, loop-length timer, and dir/setup logic.

## Test plan
- `Axes`=2, `fraction`={0x8000_0000, 0x4000_0000}, `loops`=8, `loop_cycles`=10, `dir` unchanged:
  - Axis0 steps on loops 2,4,6,8; axis1 steps on loops 4,8.
  - Each pulse is 4 cycles wide.
  - RUN lasts 80 cycles.
- Two segments queued, second with `dir[0]` flipped:
  - `dir[0]` toggles in LOAD.
  - The next step0 rising edge is ≥ 8 cycles later.
  - No step is high during the toggle.
  - `busy` never drops between the segments.
- `loop_cycles`=1, `fraction`=0xFFFF_FFFF, `loops`=4:
  - Loop length is clamped to 8 cycles.
  - Exactly 3 steps (loops 2–4).
  - Pulses do not overlap.
- `loops`=0 segment followed by a normal segment:
  - Two `data_request` pulses.
  - No steps and no dir change from the first segment.
  - The second segment executes normally.
- `reset` asserted during a step pulse mid-segment:
  - `step` = 0 and `dir` = 0 at the next edge; state is IDLE.
  - After `reset` deasserts with `data_available` = 1, `data_request` fires 1 cycle later.
- Fifo empty for the whole test:
  - `data_request` stays 0.
  - `busy` stays 0.
  - `step` stays 0.
